alu_issue_ctrl: RTL

//  Initiator side of the bit-serial ALU start/done handshake. Accepts one decoded ALU op from the

---
 rtl/alu_ctrl_pkg.sv | 39 +++
 rtl/cycle_watchdog.sv | 48 ++++
 rtl/alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types and constants for the bit-serial ALU issue controller:
//   - alu_ctrl_state_t : controller FSM states
//   - alu_op_t         : one decoded op as held stable on the ALU inputs
//   - RISC-V funct3 / funct7 encodings understood by the ALU
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        WB    = 3'd4
    } alu_ctrl_state_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic        imm_t;
        logic [4:0]  rd_addr;
    } alu_op_t;

    localparam logic [2:0] F3_ADD  = 3'h0;
    localparam logic [2:0] F3_SLL  = 3'h1;
    localparam logic [2:0] F3_SLT  = 3'h2;
    localparam logic [2:0] F3_SLTU = 3'h3;
    localparam logic [2:0] F3_XOR  = 3'h4;
    localparam logic [2:0] F3_SR   = 3'h5;
    localparam logic [2:0] F3_OR   = 3'h6;
    localparam logic [2:0] F3_AND  = 3'h7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/cycle_watchdog.sv
// ---------------------------------------------------------------------------
// cycle_watchdog
// Saturating cycle counter used to bound how long the controller waits for
// the ALU. Counts while enable is high, never wraps.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (wins over enable)
//   enable     : advance the count by one this cycle
//   expired    : count has reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module cycle_watchdog #(
    parameter int TIMEOUT_CYCLES = 128,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then saturating increment
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q >= CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the bit-serial ALU start/done handshake. Takes one op
// from the issue stage, holds it on the ALU inputs, pulses alu_start, waits
// for alu_done, and hands the result to the regfile over valid/ready.
// Ports:
//   issue_*      : op from the issue stage (valid/ready handshake)
//   alu_*  (out) : registered operands/func codes and the start pulse
//   alu_done/rd  : ALU completion pulse and result
//   wb_*         : writeback to the regfile (valid/ready handshake)
//   busy         : controller is not idle
//   timeout_err  : one-cycle pulse when the ALU fails to answer in time
// All outputs are flops, so they are 0 while rst_n is low.
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 128,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] issue_rs1,
    input  logic [31:0] issue_rs2,
    input  logic [2:0]  issue_func3,
    input  logic [6:0]  issue_func7,
    input  logic        issue_imm_t,
    input  logic [4:0]  issue_rd_addr,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [2:0]  alu_func3,
    output logic [6:0]  alu_func7,
    output logic        alu_imm_t,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [31:0] alu_rd,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        timeout_err
);

    alu_ctrl_state_t state_q, state_d;
    alu_op_t         op_q, op_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            issue_ready_q, issue_ready_d;
    logic            alu_start_q, alu_start_d;
    logic            wb_valid_q, wb_valid_d;
    logic            busy_q, busy_d;
    logic            timeout_err_q, timeout_err_d;

    logic            accept_s;
    logic            timeout_s;
    logic            wd_clear_s;
    logic            wd_enable_s;
    logic            wd_expired_s;

    assign accept_s = issue_valid && issue_ready_q;

    cycle_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // Next-state logic and watchdog control
    always_comb begin
        state_d     = state_q;
        timeout_s   = 1'b0;
        wd_clear_s  = 1'b0;
        wd_enable_s = 1'b0;
        case (state_q)
            // The ALU has no reset; wait until it is quiet before issuing.
            SYNC: begin
                wd_enable_s = 1'b1;
                if (alu_done || wd_expired_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SYNC;
                end
            end
            IDLE: begin
                if (accept_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                wd_clear_s = 1'b1;
                state_d    = WAIT;
            end
            // alu_done takes priority over a watchdog expiry in the same cycle.
            WAIT: begin
                wd_enable_s = 1'b1;
                if (alu_done) begin
                    if (op_q.rd_addr == 5'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WB;
                    end
                end else if (wd_expired_s) begin
                    // Restart the count so SYNC gets a full window to drain the ALU.
                    timeout_s  = 1'b1;
                    wd_clear_s = 1'b1;
                    state_d    = SYNC;
                end else begin
                    state_d = WAIT;
                end
            end
            WB: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WB;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // Control outputs, decoded from the next state so they leave the flops aligned with it
    always_comb begin
        issue_ready_d = (state_d == IDLE);
        alu_start_d   = (state_d == START);
        wb_valid_d    = (state_d == WB);
        busy_d        = (state_d != IDLE);
        timeout_err_d = timeout_s;
    end

    // State register and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SYNC;
            issue_ready_q <= 1'b0;
            alu_start_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_ready_q <= issue_ready_d;
            alu_start_q   <= alu_start_d;
            wb_valid_q    <= wb_valid_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Operand capture on issue and result capture on alu_done
    always_comb begin
        op_d      = op_q;
        wb_data_d = wb_data_q;
        if ((state_q == IDLE) && accept_s) begin
            op_d.rs1     = issue_rs1;
            op_d.rs2     = issue_rs2;
            op_d.func3   = issue_func3;
            op_d.func7   = issue_func7;
            op_d.imm_t   = issue_imm_t;
            op_d.rd_addr = issue_rd_addr;
        end else begin
            op_d = op_q;
        end
        if ((state_q == WAIT) && alu_done) begin
            wb_data_d = alu_rd;
        end else begin
            wb_data_d = wb_data_q;
        end
    end

    // Operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            wb_data_q <= 32'd0;
        end else begin
            op_q      <= op_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign issue_ready = issue_ready_q;
    assign alu_rs1     = op_q.rs1;
    assign alu_rs2     = op_q.rs2;
    assign alu_func3   = op_q.func3;
    assign alu_func7   = op_q.func7;
    assign alu_imm_t   = op_q.imm_t;
    assign alu_start   = alu_start_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = op_q.rd_addr;
    assign wb_data     = wb_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
